memory_arbiter: RTL and testbench

Sequential arbiter that shares the single unified RAM port between the instruction-fetch requester (icache/fetch stage) and the data requester (dcache/memory stage) of the pipelined processor. It grants one requester at a time, steers address/data/strobes to RAM, holds the loser's wait signal asserted until served, and alternates grants on contention so neither side starves. It sits between the caches and the RAM model; its wait outputs feed the hazard unit's stall logic.

---
 rtl/cpu_types_pkg.sv | 5 +
 rtl/diaosi_types_pkg.sv | 4 +
 rtl/arb_watchdog.sv | 22 ++
 rtl/memory_arbiter.sv | 75 +++++++
 tb/tb_memory_arbiter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types used by the memory system.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/diaosi_types_pkg.sv
// diaosi_types_pkg: arbiter state encoding.
package diaosi_types_pkg;
    typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I} arb_state_t;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: counts stalled grant cycles and flags a sticky abort at TIMEOUT_CYCLES.
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic abort,
    output logic arb_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign abort = hold && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt     <= '0;
            arb_err <= 1'b0;
        end else begin
            cnt     <= hold && !abort ? cnt + 1'b1 : '0;
            arb_err <= arb_err | abort;
        end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the RAM port between fetch and data, alternating on contention.
// Define ARB_TIMEOUT_EN to add a watchdog that aborts grants stuck without ACCESS.
module memory_arbiter
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      arb_err
);
    arb_state_t state, state_raw, state_next;
    logic d_req, access, abort;

    assign d_req  = dREN | dWEN;
    assign access = ramstate == ACCESS;

    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= IDLE;
        else     state <= state_next;

    // A completed grant hands over to the other side if it is waiting
    always_comb begin
        state_raw = IDLE;
        case (state)
            IDLE:    state_raw = d_req ? GRANT_D : iREN ? GRANT_I : IDLE;
            GRANT_D: state_raw = access ? (iREN ? GRANT_I : IDLE) : d_req ? GRANT_D : IDLE;
            GRANT_I: state_raw = access ? (d_req ? GRANT_D : IDLE) : iREN ? GRANT_I : IDLE;
            default: state_raw = IDLE;
        endcase
        state_next = abort ? IDLE : state_raw;
    end

    assign ramREN   = state == GRANT_I ? iREN : state == GRANT_D ? dREN & ~dWEN : 1'b0;
    assign ramWEN   = state == GRANT_D && dWEN;
    assign ramaddr  = state == GRANT_D ? daddr : state == GRANT_I ? iaddr : '0;
    assign ramstore = state == GRANT_D ? dstore : '0;
    assign iwait    = iREN & ~(state == GRANT_I && access);
    assign dwait    = d_req & ~(state == GRANT_D && access);
    assign iload    = ramload;
    assign dload    = ramload;

`ifdef ARB_TIMEOUT_EN
    logic hold;
    assign hold = state != IDLE && state_raw == state;
    arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk(CLK),
        .rst(RST),
        .hold(hold),
        .abort(abort),
        .arb_err(arb_err)
    );
`else
    assign abort   = 1'b0;
    // never true; the parameter only sizes the watchdog
    assign arb_err = TIMEOUT_CYCLES < 0;
`endif
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scoreboard bench for memory_arbiter.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      RST = 1'b1;
    logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    word_t     iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    ramstate_t ramstate = FREE;
    logic      iwait, dwait, ramREN, ramWEN, arb_err;
    word_t     iload, dload, ramaddr, ramstore;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } item_t;
    item_t sb[$];

    memory_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] probe(input string tag);
        case (tag)
            "ramREN":   return {31'b0, ramREN};
            "ramWEN":   return {31'b0, ramWEN};
            "ramaddr":  return ramaddr;
            "ramstore": return ramstore;
            "iwait":    return {31'b0, iwait};
            "dwait":    return {31'b0, dwait};
            "iload":    return iload;
            "dload":    return dload;
            "arb_err":  return {31'b0, arb_err};
            default:    return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic want(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            item_t it;
            logic [31:0] got;
            it  = sb.pop_front();
            got = probe(it.tag);
            checks++;
            assert (got === it.exp) else begin
                errors++;
                $error("FAIL %s @%0t: observed %h expected %h", it.tag, $time, got, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        drain();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // reset: ram side quiet, waits mirror live requests
        iREN = 1'b1;
        want("ramREN", 0); want("ramWEN", 0); want("ramaddr", 0); want("ramstore", 0);
        want("iwait", 1); want("dwait", 0); want("arb_err", 0);
        tick();
        RST = 1'b0; iREN = 1'b0;
        want("iwait", 0);
        tick();

        // minimum-latency fetch
        iREN = 1'b1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h1234_5678;
        want("ramREN", 0); want("iwait", 1);
        tick();
        want("ramREN", 1); want("ramaddr", 32'h40); want("iwait", 0);
        want("iload", 32'h1234_5678); want("dload", 32'h1234_5678);
        tick();
        iREN = 1'b0;
        want("ramREN", 0); want("ramaddr", 0);
        tick();

        // contention: data first with two BUSY cycles, then fetch with no gap
        iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        ramstate = BUSY;
        want("dwait", 1); want("iwait", 1); want("ramWEN", 0);
        tick();
        want("ramWEN", 1); want("ramREN", 0); want("ramaddr", 32'h100);
        want("ramstore", 32'hDEAD_BEEF); want("dwait", 1); want("iwait", 1);
        tick();
        want("ramWEN", 1); want("dwait", 1);
        tick();
        ramstate = ACCESS;
        want("ramWEN", 1); want("dwait", 0); want("iwait", 1);
        tick();
        dWEN = 1'b0;
        want("ramREN", 1); want("ramWEN", 0); want("ramaddr", 32'h80);
        want("ramstore", 0); want("iwait", 0);
        tick();
        iREN = 1'b0;
        want("ramREN", 0);
        tick();

        // both held: strict D,I alternation
        iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h200;
        want("ramaddr", 0);
        tick();
        for (int k = 1; k <= 6; k++) begin
            want("ramaddr", (k % 2) ? 32'h200 : 32'h300);
            want("dwait", (k % 2) ? 0 : 1);
            want("iwait", (k % 2) ? 1 : 0);
            want("ramREN", 1);
            tick();
        end
        iREN = 1'b0; dREN = 1'b0;
        want("ramREN", 0);
        tick();
        want("ramaddr", 0);
        tick();

        // read and write together: write wins
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h44; dstore = 32'h55;
        want("ramWEN", 0);
        tick();
        want("ramWEN", 1); want("ramREN", 0); want("ramstore", 32'h55); want("dwait", 0);
        tick();
        dREN = 1'b0; dWEN = 1'b0;
        want("ramWEN", 0); want("ramstore", 0);
        tick();

        // async reset mid-grant drops strobes at once
        iREN = 1'b1; iaddr = 32'h60; ramstate = BUSY;
        tick();
        want("ramREN", 1); want("ramaddr", 32'h60); want("iwait", 1);
        tick();
        #2 RST = 1'b1;
        #1;
        want("ramREN", 0); want("ramaddr", 0); want("iwait", 1);
        drain();
        RST = 1'b0; iREN = 1'b0;
        want("ramREN", 0); want("iwait", 0);
        tick();

        // stuck BUSY grant
        iREN = 1'b1; iaddr = 32'h70;
        want("ramREN", 0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            want("ramREN", 1); want("iwait", 1); want("arb_err", 0);
            tick();
        end
`ifdef ARB_TIMEOUT_EN
        want("ramREN", 0); want("iwait", 1); want("arb_err", 1);
        tick();
        want("ramREN", 1); want("arb_err", 1);
        tick();
        iREN = 1'b0; RST = 1'b1;
        want("arb_err", 0); want("ramREN", 0);
        tick();
        RST = 1'b0;
`else
        for (int k = 5; k <= 8; k++) begin
            want("ramREN", 1); want("iwait", 1); want("arb_err", 0);
            tick();
        end
        iREN = 1'b0;
`endif
        want("ramREN", 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
